// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline.
// Drives register enables/flushes, perf counters and memory-timeout halt.
module pipeline_ctrl #(
  parameter int CNT_W       = 32,
  parameter int WAIT_W      = 8,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hazard_stall,
  input  logic             branch_taken,
  input  logic             mem_req_MEM,
  input  logic             mem_ready,
  input  logic             imem_ready,
  input  logic             halt_req,
  output logic             pc_en,
  output logic             IF_ID_en,
  output logic             ID_EX_en,
  output logic             EX_MEM_en,
  output logic             MEM_WB_en,
  output logic             IF_ID_flush,
  output logic             ID_EX_flush,
  output logic [1:0]       state,
  output logic             halted,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    HALT     = 2'b10
  } state_t;

  localparam logic [WAIT_W-1:0] TO_V = WAIT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0]  CMAX = '1;

  state_t            st_q, st_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              to_set;
  logic              flush_inc;
  logic              stall_inc;

  always_comb begin
    st_d        = st_q;
    wait_d      = wait_q;
    to_set      = 1'b0;
    flush_inc   = 1'b0;
    pc_en       = 1'b0;
    IF_ID_en    = 1'b0;
    ID_EX_en    = 1'b0;
    EX_MEM_en   = 1'b0;
    MEM_WB_en   = 1'b0;
    IF_ID_flush = 1'b0;
    ID_EX_flush = 1'b0;
    if (!reset) begin
      unique case (st_q)
        RUN, MEM_WAIT: begin
          if (halt_req) begin
            st_d   = HALT;
            wait_d = '0;
          end else if (mem_req_MEM && !mem_ready) begin
            if (st_q == MEM_WAIT && wait_q == TO_V) begin
              st_d   = HALT;
              to_set = 1'b1;
            end else begin
              st_d   = MEM_WAIT;
              wait_d = (st_q == RUN) ? WAIT_W'(1)
                                     : wait_q + WAIT_W'(1);
            end
          end else begin
            // freeze released: resolve this cycle normally
            st_d      = RUN;
            wait_d    = '0;
            pc_en     = 1'b1;
            IF_ID_en  = 1'b1;
            ID_EX_en  = 1'b1;
            EX_MEM_en = 1'b1;
            MEM_WB_en = 1'b1;
            if (branch_taken) begin
              IF_ID_flush = 1'b1;
              ID_EX_flush = 1'b1;
              flush_inc   = 1'b1;
            end else if (hazard_stall) begin
              pc_en       = 1'b0;
              IF_ID_en    = 1'b0;
              ID_EX_flush = 1'b1;
            end else if (!imem_ready) begin
              pc_en       = 1'b0;
              IF_ID_flush = 1'b1;
            end
          end
        end
        HALT: st_d = HALT;
        default: st_d = RUN;
      endcase
    end
  end

  assign stall_inc = !pc_en && (st_q != HALT) && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q         <= RUN;
      wait_q       <= '0;
      mem_timeout  <= 1'b0;
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      st_q   <= st_d;
      wait_q <= wait_d;
      if (to_set)
        mem_timeout <= 1'b1;
      if (stall_inc && stall_cycles != CMAX)
        stall_cycles <= stall_cycles + CNT_W'(1);
      if (flush_inc && flush_count != CMAX)
        flush_count <= flush_count + CNT_W'(1);
    end
  end

  assign state  = st_q;
  assign halted = (st_q == HALT) && !reset;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed scenarios plus random stimulus
// checked against a cycle-level reference model.
module tb_pipeline_ctrl;
  localparam int CW = 4;
  localparam int WW = 8;
  localparam int TO = 4;
  localparam int SMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset, hazard_stall, branch_taken;
  logic mem_req_MEM, mem_ready, imem_ready, halt_req;
  logic pc_en, IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en;
  logic IF_ID_flush, ID_EX_flush;
  logic [1:0] state;
  logic halted, mem_timeout;
  logic [CW-1:0] stall_cycles, flush_count;

  pipeline_ctrl #(.CNT_W(CW), .WAIT_W(WW), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .hazard_stall(hazard_stall), .branch_taken(branch_taken),
    .mem_req_MEM(mem_req_MEM), .mem_ready(mem_ready),
    .imem_ready(imem_ready), .halt_req(halt_req),
    .pc_en(pc_en), .IF_ID_en(IF_ID_en), .ID_EX_en(ID_EX_en),
    .EX_MEM_en(EX_MEM_en), .MEM_WB_en(MEM_WB_en),
    .IF_ID_flush(IF_ID_flush), .ID_EX_flush(ID_EX_flush),
    .state(state), .halted(halted), .mem_timeout(mem_timeout),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  bit m_known = 0;
  bit m_halt = 0;
  bit m_wait = 0;
  bit m_to = 0;
  int m_wcnt = 0;
  int m_stall = 0;
  int m_flush = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v > SMAX) ? SMAX : v;
  endfunction

  task automatic step(input bit r, input bit h, input bit b,
                      input bit mq, input bit mr, input bit ir,
                      input bit hz);
    logic [6:0] e;
    reset = r; halt_req = h; branch_taken = b;
    mem_req_MEM = mq; mem_ready = mr;
    imem_ready = ir; hazard_stall = hz;
    @(negedge clk);
    // {pc, ifid_en, idex_en, exmem_en, memwb_en, ifid_fl, idex_fl}
    e = 7'b0;
    if (!r && !m_halt && !h && !(mq && !mr)) begin
      if (b)        e = 7'b1111111;
      else if (hz)  e = 7'b0011101;
      else if (!ir) e = 7'b0111110;
      else          e = 7'b1111100;
    end
    chk("ctrl", {25'd0, pc_en, IF_ID_en, ID_EX_en, EX_MEM_en,
                 MEM_WB_en, IF_ID_flush, ID_EX_flush}, {25'd0, e});
    chk("halted", {31'd0, halted}, {31'd0, (!r && m_halt)});
    if (m_known) begin
      chk("state", {30'd0, state},
          m_halt ? 32'd2 : (m_wait ? 32'd1 : 32'd0));
      chk("mem_timeout", {31'd0, mem_timeout}, {31'd0, m_to});
      chk("stall_cycles", {28'd0, stall_cycles}, m_stall);
      chk("flush_count", {28'd0, flush_count}, m_flush);
    end
    if (r) begin
      m_known = 1; m_halt = 0; m_wait = 0; m_to = 0;
      m_wcnt = 0; m_stall = 0; m_flush = 0;
    end else if (!m_halt) begin
      if (!e[6]) m_stall = sat(m_stall + 1);
      if (h) begin
        m_halt = 1; m_wait = 0; m_wcnt = 0;
      end else if (mq && !mr) begin
        if (m_wait && m_wcnt == TO) begin
          m_halt = 1; m_to = 1;
        end else begin
          m_wcnt = m_wait ? m_wcnt + 1 : 1;
          m_wait = 1;
        end
      end else begin
        m_wait = 0; m_wcnt = 0;
        if (b) m_flush = sat(m_flush + 1);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 1, 0);
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0, 0, 1, 0);
  endtask

  initial begin
    do_reset();
    do_reset();
    chk("rst_state", {30'd0, state}, 32'd0);
    chk("rst_stall", {28'd0, stall_cycles}, 32'd0);
    idle();

    // load-use, then branch colliding with load-use
    step(0, 0, 0, 0, 0, 1, 1);
    chk("lu_stall", {28'd0, stall_cycles}, 32'd1);
    step(0, 0, 1, 0, 0, 1, 1);
    chk("br_flush", {28'd0, flush_count}, 32'd1);
    chk("br_stall", {28'd0, stall_cycles}, 32'd1);
    step(0, 0, 0, 0, 0, 0, 0);

    // data memory wait of 3 cycles
    do_reset();
    repeat (3) step(0, 0, 0, 1, 0, 1, 0);
    chk("mw_state", {30'd0, state}, 32'd1);
    step(0, 0, 0, 1, 1, 1, 0);
    chk("mw_exit", {30'd0, state}, 32'd0);
    chk("mw_stall", {28'd0, stall_cycles}, 32'd3);

    // timeout into HALT, branch ignored there
    do_reset();
    repeat (5) step(0, 0, 0, 1, 0, 1, 0);
    chk("to_halted", {31'd0, halted}, 32'd1);
    chk("to_flag", {31'd0, mem_timeout}, 32'd1);
    step(0, 0, 1, 0, 1, 1, 0);
    chk("to_br_ign", {28'd0, flush_count}, 32'd0);

    // halt request during a memory wait
    do_reset();
    repeat (2) step(0, 0, 0, 1, 0, 1, 0);
    step(0, 1, 0, 1, 0, 1, 0);
    chk("hr_state", {30'd0, state}, 32'd2);
    chk("hr_noto", {31'd0, mem_timeout}, 32'd0);
    do_reset();
    chk("hr_rst", {30'd0, state}, 32'd0);
    chk("hr_cnt", {28'd0, stall_cycles}, 32'd0);

    // counter saturation
    repeat (20) step(0, 0, 0, 0, 0, 1, 1);
    chk("sat", {28'd0, stall_cycles}, SMAX);

    // randomized traffic
    do_reset();
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 39) == 0,
           $urandom_range(0, 59) == 0,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 2) == 0,
           $urandom_range(0, 3) != 0 || (i % 200 > 150),
           $urandom_range(0, 4) != 0,
           $urandom_range(0, 3) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
